// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, opcodes,
// datapath select codes. The JAL state exists only with MAIN_FSM_JAL_EN.
package main_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
`ifdef MAIN_FSM_JAL_EN
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`else
    S_BEQ      = 4'd9
`endif
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_ADDI  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

  // ALU operand A select
  localparam logic [SEL_W-1:0] SRC_A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_REG   = 2'b10;

  // ALU operand B select
  localparam logic [SEL_W-1:0] SRC_B_REG   = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_FOUR  = 2'b10;

  // Result bus select
  localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES  = 2'b10;

  // ALU operation class
  localparam logic [SEL_W-1:0] ALU_ADD     = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB     = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNCT   = 2'b10;

  // True when the opcode has a decode path in this build
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: legal = 1'b1;
`ifdef MAIN_FSM_JAL_EN
      OP_JAL:                                  legal = 1'b1;
`endif
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM. Moore outputs from state, except
// FETCH ir_write/pc_update (gated by mem_ready) and DECODE illegal_op.
// Optional jal support: define MAIN_FSM_JAL_EN.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_update,
  output logic             branch,
  output logic             reg_write,
  output logic             mem_write,
  output logic [SEL_W-1:0] alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] result_src,
  output logic [SEL_W-1:0] alu_op,
  output logic             illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e state_q;
  state_e state_d;

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state decode; unknown encodings and opcodes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ADDI:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MAIN_FSM_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MAIN_FSM_JAL_EN
      S_JAL:      state_d = S_ALUWB;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; everything forced low while reset is held
  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal_op = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALURES;
          ir_write   = mem_ready;
          pc_update  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a  = SRC_A_OLDPC;
          alu_src_b  = SRC_B_IMM;
          illegal_op = ~op_is_legal(op);
        end
        S_MEMADR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_EXECUTER: begin
          alu_src_a = SRC_A_REG;
          alu_op    = ALU_FUNCT;
        end
        S_EXECUTEI: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = SRC_A_REG;
          alu_op    = ALU_SUB;
          branch    = 1'b1;
        end
`ifdef MAIN_FSM_JAL_EN
        S_JAL: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_FOUR;
          pc_update = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed instruction walks with literal expectations,
// then randomized opcodes / mem_ready / reset against a route-queue model.
module tb_main_fsm;
  import main_fsm_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] M_MREQ = 16'h8000;
  localparam logic [15:0] M_ADR  = 16'h4000;
  localparam logic [15:0] M_IRW  = 16'h2000;
  localparam logic [15:0] M_PCU  = 16'h1000;
  localparam logic [15:0] M_BR   = 16'h0800;
  localparam logic [15:0] M_RW   = 16'h0400;
  localparam logic [15:0] M_MW   = 16'h0200;
  localparam logic [15:0] M_ILL  = 16'h0100;
  localparam logic [15:0] M_A    = 16'h00C0;
  localparam logic [15:0] M_B    = 16'h0030;
  localparam logic [15:0] M_RES  = 16'h000C;
  localparam logic [15:0] M_ALU  = 16'h0003;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .pc_update(pc_update),
    .branch(branch), .reg_write(reg_write), .mem_write(mem_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .illegal_op(illegal_op), .state(state)
  );

  logic [15:0] dut_vec;
  assign dut_vec = {mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write,
                    illegal_op, alu_src_a, alu_src_b, result_src, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the instruction's remaining path is a queue of steps built at decode
  state_e m_cur;
  state_e route[$];
  logic   m_valid = 1'b0;

  function automatic logic legal_op(input logic [6:0] o);
`ifdef MAIN_FSM_JAL_EN
    return o inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_JAL};
`else
    return o inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI};
`endif
  endfunction

  // Expected output word for a step, from the per-state output table
  function automatic logic [15:0] exp_vec(input state_e s, input logic rst,
                                          input logic mr, input logic [6:0] o);
    logic mreq, adr, irw, pcu, br, rw, mw, ill;
    logic [1:0] a, b, r, alu;
    {mreq, adr, irw, pcu, br, rw, mw, ill} = 8'h00;
    {a, b, r, alu} = 8'h00;
    if (!rst) begin
      case (s)
        S_FETCH:    begin mreq = 1'b1; b = 2'b10; r = 2'b10; irw = mr; pcu = mr; end
        S_DECODE:   begin a = 2'b01; b = 2'b01; ill = !legal_op(o); end
        S_MEMADR:   begin a = 2'b10; b = 2'b01; end
        S_MEMREAD:  begin mreq = 1'b1; adr = 1'b1; end
        S_MEMWRITE: begin mreq = 1'b1; adr = 1'b1; mw = 1'b1; end
        S_MEMWB:    begin r = 2'b01; rw = 1'b1; end
        S_EXECUTER: begin a = 2'b10; alu = 2'b10; end
        S_EXECUTEI: begin a = 2'b10; b = 2'b01; alu = 2'b10; end
        S_ALUWB:    begin rw = 1'b1; end
        S_BEQ:      begin a = 2'b10; alu = 2'b01; br = 1'b1; end
`ifdef MAIN_FSM_JAL_EN
        S_JAL:      begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
`endif
        default: ;
      endcase
    end
    return {mreq, adr, irw, pcu, br, rw, mw, ill, a, b, r, alu};
  endfunction

  // Model advance on each rising edge
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_cur   = S_FETCH;
      route.delete();
    end else if (m_valid) begin
      if (m_cur == S_DECODE) begin
        route.delete();
        case (op)
          OP_LW:    route = '{S_MEMADR, S_MEMREAD, S_MEMWB};
          OP_SW:    route = '{S_MEMADR, S_MEMWRITE};
          OP_RTYPE: route = '{S_EXECUTER, S_ALUWB};
          OP_ADDI:  route = '{S_EXECUTEI, S_ALUWB};
          OP_BEQ:   route = '{S_BEQ};
`ifdef MAIN_FSM_JAL_EN
          OP_JAL:   route = '{S_JAL, S_ALUWB};
`endif
          default:  route.delete();
        endcase
        m_cur = (route.size() == 0) ? S_FETCH : route.pop_front();
      end else if (m_cur == S_FETCH) begin
        if (mem_ready) m_cur = S_DECODE;
      end else if ((m_cur == S_MEMREAD || m_cur == S_MEMWRITE) && !mem_ready) begin
        m_cur = m_cur;
      end else begin
        m_cur = (route.size() == 0) ? S_FETCH : route.pop_front();
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("outputs", dut_vec, exp_vec(m_cur, reset, mem_ready, op));
      chk("state", 16'(state), 16'(m_cur));
    end
  end

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // One directed cycle: literal state plus masked literal outputs
  task automatic cyc_chk(input string n, input state_e s, input logic [15:0] mask,
                         input logic [15:0] val);
    @(negedge clk);
    chk({n, "_st"}, 16'(state), 16'(s));
    chk({n, "_out"}, dut_vec & mask, val);
    to_next();
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_JAL, 7'h00, 7'h7f};
    reset = 1'b1; mem_ready = 1'b1; op = OP_RTYPE;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outs", dut_vec, 16'h0000);
    chk("reset_state", 16'(state), 16'(S_FETCH));
    to_next();
    reset = 1'b0;

    // R-type walk
    cyc_chk("r0", S_FETCH,    M_RW | M_MREQ | M_IRW, M_MREQ | M_IRW);
    cyc_chk("r1", S_DECODE,   M_RW | M_ILL, 16'h0000);
    cyc_chk("r2", S_EXECUTER, M_RW | M_A | M_ALU, 16'h0082);
    cyc_chk("r3", S_ALUWB,    M_RW | M_RES, M_RW);

    // beq: 3 cycles, branch only in BEQ
    op = OP_BEQ;
    cyc_chk("b0", S_FETCH,  M_BR, 16'h0000);
    cyc_chk("b1", S_DECODE, M_BR, 16'h0000);
    cyc_chk("b2", S_BEQ,    M_BR | M_ALU, M_BR | 16'h0001);

    // illegal opcode
    op = 7'h00;
    cyc_chk("i0", S_FETCH,  M_ILL, 16'h0000);
    cyc_chk("i1", S_DECODE, M_ILL | M_RW | M_MW, M_ILL);

    // lw with a three-cycle memory stall
    op = OP_LW;
    cyc_chk("l0", S_FETCH,  M_MREQ, M_MREQ);
    cyc_chk("l1", S_DECODE, M_ILL, 16'h0000);
    cyc_chk("l2", S_MEMADR, M_A | M_B, 16'h0090);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc_chk("l3", S_MEMREAD, M_MREQ | M_ADR | M_IRW, M_MREQ | M_ADR);
    mem_ready = 1'b1;
    cyc_chk("l4", S_MEMREAD, M_MREQ | M_ADR, M_MREQ | M_ADR);
    cyc_chk("l5", S_MEMWB,   M_RES | M_RW, 16'h0004 | M_RW);

    // sw interrupted by reset mid-access
    op = OP_SW;
    cyc_chk("s0", S_FETCH,  M_MW, 16'h0000);
    cyc_chk("s1", S_DECODE, M_MW, 16'h0000);
    cyc_chk("s2", S_MEMADR, M_MW, 16'h0000);
    mem_ready = 1'b0;
    cyc_chk("s3", S_MEMWRITE, M_MW | M_MREQ | M_ADR, M_MW | M_MREQ | M_ADR);
    reset = 1'b1;
    cyc_chk("s4", S_MEMWRITE, 16'hFFFF, 16'h0000);
    reset = 1'b0;
    mem_ready = 1'b1;

    // jal, build dependent
    op = OP_JAL;
    cyc_chk("j0", S_FETCH, M_MREQ, M_MREQ);
`ifdef MAIN_FSM_JAL_EN
    cyc_chk("j1", S_DECODE, M_ILL, 16'h0000);
    cyc_chk("j2", S_JAL,    M_PCU | M_RES | M_A | M_B, M_PCU | 16'h0060);
    cyc_chk("j3", S_ALUWB,  M_RW, M_RW);
`else
    cyc_chk("j1", S_DECODE, M_ILL, M_ILL);
`endif
    cyc_chk("j4", S_FETCH, M_MREQ, M_MREQ);

    // Randomized run; opcode only changes while fetching
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      if (m_cur == S_FETCH) begin
        if ($urandom_range(0, 7) == 0) op = 7'($urandom);
        else                           op = ops[$urandom_range(0, 7)];
      end
      to_next();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
